dma_channel_seq: RTL and testbench

DMA_CHANNEL_SEQ -- requirements
Module: dma_channel_seq

---
 rtl/dma_pkg.sv | 48 ++++
 rtl/dma_addr_step.sv | 36 +++
 rtl/dma_channel_seq.sv | 181 ++++++++++++++++++
 tb/tb_dma_channel_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and controlH field positions for the DMA channel sequencer.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_REQ        = 3'd2,
        ST_READ       = 3'd3,
        ST_WRITE      = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        TIM_IMMEDIATE = 2'b00,
        TIM_VBLANK    = 2'b01,
        TIM_HBLANK    = 2'b10,
        TIM_SPECIAL   = 2'b11
    } timing_t;

    typedef enum logic [1:0] {
        ACTL_INC        = 2'b00,
        ACTL_DEC        = 2'b01,
        ACTL_FIXED      = 2'b10,
        ACTL_INC_RELOAD = 2'b11
    } addr_ctrl_t;

    localparam int CTL_ENABLE    = 15;
    localparam int CTL_IRQ_EN    = 14;
    localparam int CTL_TIMING_HI = 13;
    localparam int CTL_TIMING_LO = 12;
    localparam int CTL_WORD      = 10;
    localparam int CTL_REPEAT    = 9;
    localparam int CTL_SRC_HI    = 8;
    localparam int CTL_SRC_LO    = 7;
    localparam int CTL_DST_HI    = 6;
    localparam int CTL_DST_LO    = 5;

    // A programmed count of zero stands for the full range of the counter.
    function automatic logic [16:0] count_load(input logic [15:0] raw, input logic wide);
        logic [16:0] c;
        c = wide ? {1'b0, raw} : {3'b000, raw[13:0]};
        if (c == 17'd0) begin
            c = wide ? 17'h10000 : 17'h04000;
        end
        return c;
    endfunction

endpackage

// File: rtl/dma_addr_step.sv
// Address masking/alignment on load and per-unit stepping (inc/dec/fixed) modulo AW bits.
module dma_addr_step
    import dma_pkg::*;
#(
    parameter int AW = 27
) (
    input  logic [31:0] raw_addr,
    input  logic        load_word,
    input  logic [31:0] cur_addr,
    input  addr_ctrl_t  ctrl,
    input  logic        step_word,
    output logic [31:0] load_addr,
    output logic [31:0] next_addr
);

    localparam logic [31:0] MASK = 32'hFFFF_FFFF >> (32 - AW);

    logic [31:0] step;
    logic [31:0] sum;

    assign load_addr = raw_addr & MASK & (load_word ? ~32'd3 : ~32'd1);
    assign step      = step_word ? 32'd4 : 32'd2;

    always_comb begin
        sum = cur_addr + step;
        case (ctrl)
            ACTL_DEC:   sum = cur_addr - step;
            ACTL_FIXED: sum = cur_addr;
            default:    sum = cur_addr + step;
        endcase
    end

    // Aligned start plus aligned step keeps the address aligned after the wrap.
    assign next_addr = sum & MASK;

endmodule

// File: rtl/dma_channel_seq.sv
// One DMA channel: latch on enable rise, wait for start, copy units read->write.
// Optional macro DMA_REPEAT_EN enables repeat-mode reload at completion.
module dma_channel_seq
    import dma_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] controlL,
    input  logic [15:0] controlH,
    input  logic [15:0] srcAddrL,
    input  logic [15:0] srcAddrH,
    input  logic [15:0] destAddrL,
    input  logic [15:0] destAddrH,
    input  logic        hblank,
    input  logic        vblank,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic        mem_size,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        irq,
    output logic        enable_clear,
    output logic        active
);

    localparam int   SRC_AW     = (CHANNEL == 0) ? 27 : 28;
    localparam int   DST_AW     = (CHANNEL == 3) ? 28 : 27;
    localparam logic WIDE_COUNT = (CHANNEL == 3);
`ifdef DMA_REPEAT_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    state_t     state_reg, state_next;
    logic       enable_q;
    logic [31:0] src_reg, dst_reg;
    logic [16:0] count_reg;
    logic       word_reg, irq_en_reg, repeat_reg;
    timing_t    timing_reg;
    addr_ctrl_t src_ctrl_reg, dst_ctrl_reg;

    logic [31:0] src_load, src_step, dst_load, dst_step;
    logic        enable_rise, start_hit, repeat_take;
    logic        unused_bits;

    assign unused_bits = ^{controlH[11], controlH[4:0]};
    assign enable_rise = controlH[CTL_ENABLE] & ~enable_q;
    assign repeat_take = REPEAT_EN & repeat_reg & (timing_reg != TIM_IMMEDIATE);
    assign active      = (state_reg != ST_IDLE);

    always_comb begin
        case (timing_reg)
            TIM_IMMEDIATE: start_hit = 1'b1;
            TIM_VBLANK:    start_hit = vblank;
            TIM_HBLANK:    start_hit = hblank;
            default:       start_hit = 1'b0;
        endcase
    end

    dma_addr_step #(.AW(SRC_AW)) u_src_step (
        .raw_addr  ({srcAddrH, srcAddrL}),
        .load_word (controlH[CTL_WORD]),
        .cur_addr  (src_reg),
        .ctrl      (src_ctrl_reg),
        .step_word (word_reg),
        .load_addr (src_load),
        .next_addr (src_step)
    );

    dma_addr_step #(.AW(DST_AW)) u_dst_step (
        .raw_addr  ({destAddrH, destAddrL}),
        .load_word (controlH[CTL_WORD]),
        .cur_addr  (dst_reg),
        .ctrl      (dst_ctrl_reg),
        .step_word (word_reg),
        .load_addr (dst_load),
        .next_addr (dst_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bus_req      = 1'b0;
        mem_addr     = 32'd0;
        mem_we       = 1'b0;
        mem_size     = 1'b0;
        mem_wdata    = 32'd0;
        irq          = 1'b0;
        enable_clear = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (enable_rise) state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!controlH[CTL_ENABLE]) state_next = ST_IDLE;
                else if (start_hit)        state_next = ST_REQ;
            end
            ST_REQ: begin
                bus_req = 1'b1;
                if (!controlH[CTL_ENABLE]) state_next = ST_IDLE;
                else if (bus_grant)        state_next = ST_READ;
            end
            ST_READ: begin
                bus_req    = 1'b1;
                mem_addr   = src_reg;
                mem_size   = word_reg;
                state_next = ST_WRITE;
            end
            ST_WRITE: begin
                // Read data arrives this cycle and is forwarded straight to the write.
                bus_req   = 1'b1;
                mem_addr  = dst_reg;
                mem_we    = 1'b1;
                mem_size  = word_reg;
                mem_wdata = mem_rdata;
                if (!controlH[CTL_ENABLE])  state_next = ST_IDLE;
                else if (count_reg == 17'd1) state_next = ST_DONE;
                else if (bus_grant)          state_next = ST_READ;
                else                         state_next = ST_REQ;
            end
            ST_DONE: begin
                irq = irq_en_reg;
                if (repeat_take) begin
                    state_next = ST_WAIT_START;
                end else begin
                    enable_clear = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q     <= 1'b0;
            src_reg      <= 32'd0;
            dst_reg      <= 32'd0;
            count_reg    <= 17'd0;
            word_reg     <= 1'b0;
            irq_en_reg   <= 1'b0;
            repeat_reg   <= 1'b0;
            timing_reg   <= TIM_IMMEDIATE;
            src_ctrl_reg <= ACTL_INC;
            dst_ctrl_reg <= ACTL_INC;
        end else begin
            enable_q <= controlH[CTL_ENABLE];
            if (state_reg == ST_IDLE && enable_rise) begin
                src_reg      <= src_load;
                dst_reg      <= dst_load;
                count_reg    <= count_load(controlL, WIDE_COUNT);
                word_reg     <= controlH[CTL_WORD];
                irq_en_reg   <= controlH[CTL_IRQ_EN];
                repeat_reg   <= controlH[CTL_REPEAT];
                timing_reg   <= timing_t'(controlH[CTL_TIMING_HI:CTL_TIMING_LO]);
                src_ctrl_reg <= addr_ctrl_t'(controlH[CTL_SRC_HI:CTL_SRC_LO]);
                dst_ctrl_reg <= addr_ctrl_t'(controlH[CTL_DST_HI:CTL_DST_LO]);
            end else if (state_reg == ST_WRITE) begin
                src_reg   <= src_step;
                dst_reg   <= dst_step;
                count_reg <= count_reg - 17'd1;
            end else if (state_reg == ST_DONE && repeat_take) begin
                count_reg <= count_load(controlL, WIDE_COUNT);
                if (dst_ctrl_reg == ACTL_INC_RELOAD) dst_reg <= dst_load;
            end
        end
    end

endmodule

// File: tb/tb_dma_channel_seq.sv
// Directed bench for dma_channel_seq: CH0 vector table plus grant, repeat (CH3) and reset sequences.
module tb_dma_channel_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] ctl_l, ctl_h;
    logic [31:0] src_a, dst_a;
    logic        hblank, vblank, bus_grant;
    logic        bus_req, mem_we, mem_size, irq, enable_clear, active;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] c3_ctl_l, c3_ctl_h;
    logic [31:0] c3_src, c3_dst;
    logic        c3_hblank, c3_vblank;
    logic        c3_bus_req, c3_mem_we, c3_mem_size, c3_irq, c3_ec, c3_active;
    logic [31:0] c3_mem_addr, c3_mem_wdata, c3_mem_rdata;

    int compared = 0;
    int mismatched = 0;
    int cycle = 0;

    dma_channel_seq #(.CHANNEL(0)) u_dut (
        .clk(clk), .rst(rst),
        .controlL(ctl_l), .controlH(ctl_h),
        .srcAddrL(src_a[15:0]), .srcAddrH(src_a[31:16]),
        .destAddrL(dst_a[15:0]), .destAddrH(dst_a[31:16]),
        .hblank(hblank), .vblank(vblank),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_size(mem_size),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .irq(irq), .enable_clear(enable_clear), .active(active)
    );

    dma_channel_seq #(.CHANNEL(3)) u_ch3 (
        .clk(clk), .rst(rst),
        .controlL(c3_ctl_l), .controlH(c3_ctl_h),
        .srcAddrL(c3_src[15:0]), .srcAddrH(c3_src[31:16]),
        .destAddrL(c3_dst[15:0]), .destAddrH(c3_dst[31:16]),
        .hblank(c3_hblank), .vblank(c3_vblank),
        .bus_req(c3_bus_req), .bus_grant(1'b1),
        .mem_addr(c3_mem_addr), .mem_we(c3_mem_we), .mem_size(c3_mem_size),
        .mem_wdata(c3_mem_wdata), .mem_rdata(c3_mem_rdata),
        .irq(c3_irq), .enable_clear(c3_ec), .active(c3_active)
    );

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction

    always @(posedge clk) begin
        cycle        <= cycle + 1;
        mem_rdata    <= rd_fn(mem_addr);
        c3_mem_rdata <= rd_fn(c3_mem_addr);
    end

    logic [31:0] wr_addr_q[$], wr_data_q[$], c3_addr_q[$], c3_data_q[$];
    int          wr_cyc_q[$], ec_cyc_q[$];
    int          irq_cnt = 0;
    int          c3_ec_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
            wr_cyc_q.push_back(cycle);
        end
        if (irq) irq_cnt++;
        if (enable_clear) ec_cyc_q.push_back(cycle);
        if (c3_mem_we) begin
            c3_addr_q.push_back(c3_mem_addr);
            c3_data_q.push_back(c3_mem_wdata);
        end
        if (c3_ec) c3_ec_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (enable_clear) begin
                ctl_h[15] = 1'b0;
                done = 1'b1;
            end
        end
        check("completion_within_budget", {31'd0, done}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic start_ch0(input logic [31:0] s, input logic [31:0] d,
                             input logic [15:0] cl, input logic [15:0] ch);
        src_a = s; dst_a = d; ctl_l = cl; ctl_h = ch & 16'h7FFF;
        @(negedge clk);
        ctl_h = ch;
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] cl;
        logic [15:0] ch;
        int          n;
        logic [31:0] first_dst;
        logic [31:0] last_dst;
        logic [31:0] last_src;
        int          irqs;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base_w, base_i, base_e, nw, seen;

        vecs[0] = '{32'h0000_0000, 32'h0500_000A, 16'd1,     16'hC000, 1,
                    32'h0500_000A, 32'h0500_000A, 32'h0000_0000, 1};
        vecs[1] = '{32'h0200_0000, 32'h0300_0008, 16'd8,     16'hC400, 8,
                    32'h0300_0008, 32'h0300_0024, 32'h0200_001C, 1};
        vecs[2] = '{32'h0200_0010, 32'h0300_0021, 16'd3,     16'h80A0, 3,
                    32'h0300_0020, 32'h0300_001C, 32'h0200_000C, 0};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0400_0003, 16'd2,     16'h8440, 2,
                    32'h0400_0000, 32'h0400_0000, 32'h0000_0000, 0};
        vecs[4] = '{32'h0200_0100, 32'h0600_0000, 16'hC002,  16'hC160, 2,
                    32'h0600_0000, 32'h0600_0002, 32'h0200_0100, 1};
        vecs[5] = '{32'h0200_0000, 32'h0300_0000, 16'd0,     16'h8140, 16384,
                    32'h0300_0000, 32'h0300_0000, 32'h0200_0000, 0};

        rst = 1'b1; ctl_l = '0; ctl_h = '0; src_a = '0; dst_a = '0;
        hblank = 1'b0; vblank = 1'b0; bus_grant = 1'b1;
        c3_ctl_l = '0; c3_ctl_h = '0; c3_src = '0; c3_dst = '0;
        c3_hblank = 1'b0; c3_vblank = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_bus_req", {31'd0, bus_req}, 32'd0);
        check("reset_active", {31'd0, active}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            base_w = wr_addr_q.size(); base_i = irq_cnt; base_e = ec_cyc_q.size();
            start_ch0(vecs[v].src, vecs[v].dst, vecs[v].cl, vecs[v].ch);
            wait_done(2 * vecs[v].n + 20);
            nw = wr_addr_q.size() - base_w;
            check($sformatf("v%0d_writes", v), nw, vecs[v].n);
            check($sformatf("v%0d_irqs", v), irq_cnt - base_i, vecs[v].irqs);
            check($sformatf("v%0d_enable_clears", v), ec_cyc_q.size() - base_e, 1);
            if (nw > 0 && ec_cyc_q.size() > base_e) begin
                check($sformatf("v%0d_first_dst", v), wr_addr_q[base_w], vecs[v].first_dst);
                check($sformatf("v%0d_last_dst", v), wr_addr_q[base_w + nw - 1], vecs[v].last_dst);
                check($sformatf("v%0d_last_data", v), wr_data_q[base_w + nw - 1], rd_fn(vecs[v].last_src));
                check($sformatf("v%0d_read_to_done", v),
                      ec_cyc_q[base_e] - (wr_cyc_q[base_w] - 1), 2 * vecs[v].n);
            end
            $display("vector %0d: src=0x%08h dst=0x%08h ctlL=0x%04h ctlH=0x%04h writes=%0d",
                     v, vecs[v].src, vecs[v].dst, vecs[v].cl, vecs[v].ch, nw);
        end

        // Grant withdrawn after the second unit: requests stay up, no writes, then resume.
        base_w = wr_addr_q.size();
        start_ch0(32'h0, 32'h0300_0000, 16'd4, 16'h8500);
        seen = 0;
        for (int i = 0; i < 40 && seen < 2; i++) begin
            @(negedge clk);
            if (mem_we) seen++;
        end
        check("grant_two_units_before_drop", seen, 2);
        bus_grant = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("grant_gap_bus_req", {31'd0, bus_req}, 32'd1);
            check("grant_gap_no_write", {31'd0, mem_we}, 32'd0);
        end
        bus_grant = 1'b1;
        wait_done(40);
        nw = wr_addr_q.size() - base_w;
        check("grant_total_writes", nw, 4);
        for (int k = 0; k < nw && k < 4; k++)
            check("grant_fixed_src_data", wr_data_q[base_w + k], rd_fn(32'h0));
        if (nw > 0) check("grant_last_dst", wr_addr_q[base_w + nw - 1], 32'h0300_000C);
        $display("grant sequence: writes=%0d", nw);

        // CH3 hblank-timed, repeat bit set, dst reload control.
        c3_src = 32'h0800_0000; c3_dst = 32'h0A00_0000; c3_ctl_l = 16'd2; c3_ctl_h = 16'h2260;
        @(negedge clk);
        c3_ctl_h = 16'hA260;
        repeat (6) @(negedge clk);
        check("c3_waiting_active", {31'd0, c3_active}, 32'd1);
        c3_vblank = 1'b1; @(negedge clk); c3_vblank = 1'b0;
        repeat (4) @(negedge clk);
        check("c3_vblank_ignored", c3_addr_q.size(), 0);
        c3_hblank = 1'b1; @(negedge clk); c3_hblank = 1'b0;
        repeat (12) @(negedge clk);
        check("c3_burst1_writes", c3_addr_q.size(), 2);
        if (c3_addr_q.size() >= 2) begin
            check("c3_burst1_dst0", c3_addr_q[0], 32'h0A00_0000);
            check("c3_burst1_dst1", c3_addr_q[1], 32'h0A00_0002);
            check("c3_burst1_data1", c3_data_q[1], rd_fn(32'h0800_0002));
        end
`ifdef DMA_REPEAT_EN
        check("c3_repeat_no_enable_clear", c3_ec_cnt, 0);
        check("c3_repeat_still_active", {31'd0, c3_active}, 32'd1);
        c3_hblank = 1'b1; @(negedge clk); c3_hblank = 1'b0;
        repeat (12) @(negedge clk);
        check("c3_burst2_writes", c3_addr_q.size(), 4);
        if (c3_addr_q.size() >= 4) begin
            check("c3_burst2_dst_reloaded", c3_addr_q[2], 32'h0A00_0000);
            check("c3_burst2_dst1", c3_addr_q[3], 32'h0A00_0002);
            check("c3_burst2_src_continues", c3_data_q[2], rd_fn(32'h0800_0004));
        end
        check("c3_burst2_no_enable_clear", c3_ec_cnt, 0);
        c3_ctl_h[15] = 1'b0;
        repeat (3) @(negedge clk);
        check("c3_idle_after_disable", {31'd0, c3_active}, 32'd0);
`else
        check("c3_single_enable_clear", c3_ec_cnt, 1);
        c3_ctl_h[15] = 1'b0;
        check("c3_idle_after_burst", {31'd0, c3_active}, 32'd0);
        c3_hblank = 1'b1; @(negedge clk); c3_hblank = 1'b0;
        repeat (12) @(negedge clk);
        check("c3_no_second_burst", c3_addr_q.size(), 2);
`endif
        $display("ch3 repeat sequence: writes=%0d enable_clears=%0d", c3_addr_q.size(), c3_ec_cnt);

        // Reset asserted in the middle of a WRITE cycle.
        start_ch0(32'h0, 32'h0300_0000, 16'd4, 16'h8000);
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (mem_we) seen = 1;
        end
        check("rst_reached_write", seen, 1);
        rst = 1'b1; ctl_h = '0;
        #1;
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_size", {31'd0, mem_size}, 32'd0);
        check("rst_active", {31'd0, active}, 32'd0);
        check("rst_irq_ec", {30'd0, irq, enable_clear}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        base_w = wr_addr_q.size();
        repeat (6) @(negedge clk);
        check("rst_no_more_writes", wr_addr_q.size() - base_w, 0);
        check("rst_stays_idle", {31'd0, active}, 32'd0);
        $display("reset sequence: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
